// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_pkg : shared constants and helpers for the pwm_multi block        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_EDGE   = 0;
  localparam int PWM_CENTER = 1;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_timebase : prescaler plus sawtooth/triangle counter for PWM       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int PRESCALE_W     = 8,
  parameter int CENTER_ALIGNED = PWM_EDGE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      cnt,
  output logic                  tick,
  output logic                  boundary
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [PRESCALE_W-1:0] r_presc;
  logic [WIDTH-1:0]      r_cnt;
  logic                  r_up;
  logic                  w_tick;
  logic                  w_boundary;
  logic [WIDTH-1:0]      w_cnt_nxt;
  logic                  w_up_nxt;

  // Exact compare: a prescale lowered below r_presc lets it wrap through all-ones.
  assign w_tick = enable & (r_presc == prescale);

  generate
    if (CENTER_ALIGNED == PWM_CENTER) begin : g_center
      always_comb begin
        w_cnt_nxt = r_cnt;
        w_up_nxt  = r_up;
        if (r_up) begin
          w_cnt_nxt = r_cnt + C_ONE;
          if (r_cnt == C_MAX - C_ONE) w_up_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
          if (r_cnt == C_ONE) w_up_nxt = 1'b1;
        end
      end
      assign w_boundary = w_tick & ~r_up & (r_cnt == C_ONE);
    end else begin : g_edge
      assign w_cnt_nxt  = (r_cnt == C_MAX) ? '0 : r_cnt + C_ONE;
      assign w_up_nxt   = 1'b1;
      assign w_boundary = w_tick & r_up & (r_cnt == C_MAX);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_up    <= 1'b1;
    end else if (!enable) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_up    <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRESCALE_W'(1);
      if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        r_up  <= w_up_nxt;
      end
    end
  end

  assign cnt      = r_cnt;
  assign tick     = w_tick;
  assign boundary = w_boundary;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_multi : multi-channel PWM with double-buffered duty registers     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int WIDTH          = 10,
  parameter int PRESCALE_W     = 8,
  parameter int CENTER_ALIGNED = PWM_EDGE,
  parameter int CH_W           = ch_width(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_tick,
  output logic [NUM_CH-1:0]     pending
);

  logic [WIDTH-1:0]  w_cnt;
  logic              w_tick;
  logic              w_boundary;
  logic [NUM_CH-1:0] w_sel;
  logic              w_ch_busy;
  logic              w_accept;
  logic              r_period_tick;

  pwm_timebase #(
    .WIDTH          (WIDTH),
    .PRESCALE_W     (PRESCALE_W),
    .CENTER_ALIGNED (CENTER_ALIGNED)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .prescale (prescale),
    .cnt      (w_cnt),
    .tick     (w_tick),
    .boundary (w_boundary)
  );

  // Out-of-range channels select nothing, so they are never busy and get dropped.
  assign w_ch_busy = |(pending & w_sel);
  assign wr_ready  = rst_n & ~w_ch_busy;
  assign w_accept  = wr_valid & wr_ready;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH-1:0] r_shadow;
      logic [WIDTH-1:0] r_act;
      logic             r_pend;
      logic             r_pwm;
      logic             w_wr;

      assign w_sel[i] = (wr_ch == CH_W'(i));
      assign w_wr     = w_accept & w_sel[i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow <= '0;
          r_act    <= '0;
          r_pend   <= 1'b0;
          r_pwm    <= 1'b0;
        end else begin
          if (!enable) begin
            // Idle: flush any shadow, and let writes land directly.
            if (r_pend) begin
              r_act  <= r_shadow;
              r_pend <= 1'b0;
            end else if (w_wr) begin
              r_act <= wr_duty;
            end
          end else if (w_wr) begin
            r_shadow <= wr_duty;
            r_pend   <= 1'b1;
          end else if (w_boundary && r_pend) begin
            r_act  <= r_shadow;
            r_pend <= 1'b0;
          end
          r_pwm <= enable & (w_cnt < r_act);
        end
      end

      assign pwm_out[i] = r_pwm;
      assign pending[i] = r_pend;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= w_tick & w_boundary;
    end
  end

  assign period_tick = r_period_tick;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// Bench for pwm_multi: an edge-aligned and a centre-aligned instance (WIDTH=4,
// NUM_CH=2) checked against a tick-count based reference model.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] prescale;
  logic       wr_valid_e, wr_valid_c;
  logic       wr_ch;
  logic [3:0] wr_duty;
  logic       rdy_e, rdy_c;
  logic [1:0] pwm_e, pwm_c;
  logic       tick_e, tick_c;
  logic [1:0] pend_e, pend_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multi #(.NUM_CH(2), .WIDTH(4), .PRESCALE_W(8), .CENTER_ALIGNED(0)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale),
    .wr_valid(wr_valid_e), .wr_ready(rdy_e), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_e), .period_tick(tick_e), .pending(pend_e)
  );

  pwm_multi #(.NUM_CH(2), .WIDTH(4), .PRESCALE_W(8), .CENTER_ALIGNED(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale),
    .wr_valid(wr_valid_c), .wr_ready(rdy_c), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_c), .period_tick(tick_c), .pending(pend_c)
  );

  // Reference model: counter value derived from the number of elapsed ticks.
  // Index 0 = edge-aligned (period 16 ticks), 1 = centre-aligned (period 30).
  int unsigned m_k;
  logic [3:0]  m_act  [2][2];
  logic [3:0]  m_sh   [2][2];
  logic [1:0]  m_pend [2];
  logic [1:0]  m_pwm  [2];
  logic        m_tick [2];

  function automatic int cnt_at(input int d, input int unsigned t);
    int unsigned p;
    if (d == 0) return int'(t % 16);
    p = t % 30;
    return (p <= 15) ? int'(p) : int'(30 - p);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned pp, t;
    logic tk, bnd, acc, wv;
    int c;
    if (!rst_n) begin
      m_k <= 0;
      for (int d = 0; d < 2; d++) begin
        m_pend[d] <= '0;
        m_pwm[d]  <= '0;
        m_tick[d] <= 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
          m_act[d][ch] <= '0;
          m_sh[d][ch]  <= '0;
        end
      end
    end else begin
      pp = 32'(prescale) + 1;
      t  = m_k / pp;
      tk = enable && (m_k % pp == pp - 1);
      for (int d = 0; d < 2; d++) begin
        c   = cnt_at(d, t);
        bnd = tk && ((d == 0) ? (t % 16 == 15) : (t % 30 == 29));
        wv  = (d == 0) ? wr_valid_e : wr_valid_c;
        acc = wv && !m_pend[d][wr_ch];
        m_tick[d] <= bnd;
        for (int ch = 0; ch < 2; ch++) begin
          m_pwm[d][ch] <= enable && (c < int'(m_act[d][ch]));
          if (!enable) begin
            if (m_pend[d][ch]) begin
              m_act[d][ch]  <= m_sh[d][ch];
              m_pend[d][ch] <= 1'b0;
            end else if (acc && int'(wr_ch) == ch) begin
              m_act[d][ch] <= wr_duty;
            end
          end else if (acc && int'(wr_ch) == ch) begin
            m_sh[d][ch]   <= wr_duty;
            m_pend[d][ch] <= 1'b1;
          end else if (bnd && m_pend[d][ch]) begin
            m_act[d][ch]  <= m_sh[d][ch];
            m_pend[d][ch] <= 1'b0;
          end
        end
      end
      m_k <= enable ? m_k + 1 : 0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; prescale = 8'd0;
    wr_valid_e = 1'b0; wr_valid_c = 1'b0; wr_ch = 1'b0; wr_duty = 4'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({pwm_e, tick_e, pend_e, rdy_e} !== 6'b0)
      begin bad++; $display("FAIL reset_edge got=%b want=000000", {pwm_e, tick_e, pend_e, rdy_e}); end
    total++;
    if ({pwm_c, tick_c, pend_c, rdy_c} !== 6'b0)
      begin bad++; $display("FAIL reset_center got=%b want=000000", {pwm_c, tick_c, pend_c, rdy_c}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({rdy_e, rdy_c} !== 2'b11)
      begin bad++; $display("FAIL ready_after_reset got=%b want=11", {rdy_e, rdy_c}); end
  endtask

  task automatic test_edge_idle();
    int last = -1;
    enable = 1'b1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      total++;
      if ({pwm_e, tick_e, pend_e} !== {m_pwm[0], m_tick[0], m_pend[0]})
        begin bad++; $display("FAIL idle_edge_model t=%0t got=%b want=%b", $time, {pwm_e, tick_e, pend_e}, {m_pwm[0], m_tick[0], m_pend[0]}); end
      total++;
      if (pwm_e !== 2'b00)
        begin bad++; $display("FAIL idle_edge_low t=%0t got=%b want=00", $time, pwm_e); end
      if (tick_e) begin
        if (last >= 0) begin
          total++;
          if (cyc - last != 16)
            begin bad++; $display("FAIL idle_tick_spacing got=%0d want=16", cyc - last); end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_edge_write();
    int n, highs;
    @(negedge clk); enable = 1'b0; prescale = 8'd0;
    @(negedge clk); enable = 1'b1;
    n = 0;
    while (m_k % 16 != 7 && n < 40) begin @(negedge clk); n++; end
    wr_ch = 1'b0; wr_duty = 4'd4; wr_valid_e = 1'b1;
    @(negedge clk);
    wr_duty = 4'd9;
    #1;
    total++;
    if (pend_e[0] !== 1'b1 || rdy_e !== 1'b0)
      begin bad++; $display("FAIL write_pending got pend=%b rdy=%b want pend[0]=1 rdy=0", pend_e, rdy_e); end
    repeat (3) @(negedge clk);
    wr_valid_e = 1'b0;
    total++;
    if (pend_e[0] !== 1'b1)
      begin bad++; $display("FAIL write_stall got pend=%b want pend[0]=1", pend_e); end
    n = 0;
    while (!tick_e && n < 40) begin @(negedge clk); n++; end
    total++;
    if (!tick_e) begin bad++; $display("FAIL write_tick_timeout got=0 want=1"); end
    total++;
    if (pend_e !== 2'b00)
      begin bad++; $display("FAIL write_applied got pend=%b want=00", pend_e); end
    highs = 0;
    for (int i = 0; i < 16; i++) begin highs += int'(pwm_e[0]); @(negedge clk); end
    total++;
    if (highs != 4) begin bad++; $display("FAIL edge_duty4_highs got=%0d want=4", highs); end
  endtask

  task automatic test_prescale();
    int n, highs;
    @(negedge clk); enable = 1'b0; prescale = 8'd2;
    @(negedge clk); wr_ch = 1'b1; wr_duty = 4'd8; wr_valid_e = 1'b1;
    @(negedge clk); wr_valid_e = 1'b0; enable = 1'b1;
    n = 0;
    while (!tick_e && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!tick_e) begin bad++; $display("FAIL presc_tick_timeout got=0 want=1"); end
    highs = 0;
    for (int i = 0; i < 48; i++) begin
      highs += int'(pwm_e[1]);
      total++;
      if ({pwm_e, tick_e, pend_e} !== {m_pwm[0], m_tick[0], m_pend[0]})
        begin bad++; $display("FAIL presc_model t=%0t got=%b want=%b", $time, {pwm_e, tick_e, pend_e}, {m_pwm[0], m_tick[0], m_pend[0]}); end
      @(negedge clk);
    end
    total++;
    if (highs != 24) begin bad++; $display("FAIL presc_duty8_highs got=%0d want=24", highs); end
    total++;
    if (tick_e !== 1'b1) begin bad++; $display("FAIL presc_period48 got=%b want=1", tick_e); end
    wr_ch = 1'b1; wr_duty = 4'd15; wr_valid_e = 1'b1;
    @(negedge clk); wr_valid_e = 1'b0;
    n = 0;
    while (!tick_e && n < 100) begin @(negedge clk); n++; end
    highs = 0;
    for (int i = 0; i < 48; i++) begin highs += int'(pwm_e[1]); @(negedge clk); end
    total++;
    if (highs != 45) begin bad++; $display("FAIL presc_duty15_highs got=%0d want=45", highs); end
  endtask

  task automatic test_center();
    int n, highs;
    @(negedge clk); enable = 1'b0; prescale = 8'd0;
    @(negedge clk); wr_ch = 1'b0; wr_duty = 4'd4; wr_valid_c = 1'b1;
    @(negedge clk); wr_valid_c = 1'b0; enable = 1'b1;
    n = 0;
    while (!tick_c && n < 60) begin @(negedge clk); n++; end
    total++;
    if (n != 30) begin bad++; $display("FAIL center_first_tick got=%0d want=30", n); end
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      highs += int'(pwm_c[0]);
      total++;
      if ({pwm_c, tick_c, pend_c} !== {m_pwm[1], m_tick[1], m_pend[1]})
        begin bad++; $display("FAIL center_model t=%0t got=%b want=%b", $time, {pwm_c, tick_c, pend_c}, {m_pwm[1], m_tick[1], m_pend[1]}); end
      @(negedge clk);
    end
    total++;
    if (highs != 7) begin bad++; $display("FAIL center_duty4_highs got=%0d want=7", highs); end
    total++;
    if (tick_c !== 1'b1) begin bad++; $display("FAIL center_period30 got=%b want=1", tick_c); end
  endtask

  task automatic test_disabled_write();
    int highs = 0;
    int first = -1;
    @(negedge clk); enable = 1'b0; prescale = 8'd0;
    @(negedge clk); wr_ch = 1'b0; wr_duty = 4'd9; wr_valid_e = 1'b1; wr_valid_c = 1'b1;
    @(negedge clk); wr_valid_e = 1'b0; wr_valid_c = 1'b0;
    total++;
    if ({pend_e, pend_c} !== 4'b0)
      begin bad++; $display("FAIL disabled_no_pending got=%b want=0000", {pend_e, pend_c}); end
    enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      highs += int'(pwm_e[0]);
      if (tick_e && first < 0) first = i;
    end
    total++;
    if (highs != 9) begin bad++; $display("FAIL disabled_duty9_highs got=%0d want=9", highs); end
    total++;
    if (first != 16) begin bad++; $display("FAIL enable_first_tick got=%0d want=16", first); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      enable = 1'b0; wr_valid_e = 1'b0; wr_valid_c = 1'b0;
      prescale = 8'($urandom_range(0, 3));
      @(negedge clk); enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        total++;
        if ({pwm_e, tick_e, pend_e} !== {m_pwm[0], m_tick[0], m_pend[0]})
          begin bad++; $display("FAIL rand_edge t=%0t got=%b want=%b", $time, {pwm_e, tick_e, pend_e}, {m_pwm[0], m_tick[0], m_pend[0]}); end
        total++;
        if ({pwm_c, tick_c, pend_c} !== {m_pwm[1], m_tick[1], m_pend[1]})
          begin bad++; $display("FAIL rand_center t=%0t got=%b want=%b", $time, {pwm_c, tick_c, pend_c}, {m_pwm[1], m_tick[1], m_pend[1]}); end
        wr_valid_e = ($urandom_range(0, 3) == 0);
        wr_valid_c = ($urandom_range(0, 3) == 0);
        wr_ch      = 1'($urandom_range(0, 1));
        wr_duty    = 4'($urandom);
        if ($urandom_range(0, 79) == 0) enable = ~enable;
        #1;
        total++;
        if ({rdy_e, rdy_c} !== {~m_pend[0][wr_ch], ~m_pend[1][wr_ch]})
          begin bad++; $display("FAIL rand_ready t=%0t got=%b want=%b", $time, {rdy_e, rdy_c}, {~m_pend[0][wr_ch], ~m_pend[1][wr_ch]}); end
      end
    end
    @(negedge clk); wr_valid_e = 1'b0; wr_valid_c = 1'b0;
  endtask

  task automatic test_async_reset();
    int n, highs;
    @(negedge clk); enable = 1'b0; prescale = 8'd0;
    @(negedge clk); wr_ch = 1'b0; wr_duty = 4'd12; wr_valid_e = 1'b1; wr_valid_c = 1'b1;
    @(negedge clk); wr_valid_e = 1'b0; wr_valid_c = 1'b0; enable = 1'b1;
    n = 0;
    while (!(pwm_e[0] && pwm_c[0]) && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!(pwm_e[0] && pwm_c[0])) begin bad++; $display("FAIL arst_high_phase got=%b%b want=11", pwm_e[0], pwm_c[0]); end
    wr_ch = 1'b1; wr_duty = 4'd5; wr_valid_e = 1'b1; wr_valid_c = 1'b1;
    @(negedge clk); wr_valid_e = 1'b0; wr_valid_c = 1'b0;
    total++;
    if (pend_e[1] !== 1'b1 || pend_c[1] !== 1'b1)
      begin bad++; $display("FAIL arst_pending_set got=%b%b want=11", pend_e[1], pend_c[1]); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pwm_e, tick_e, pend_e, rdy_e, pwm_c, tick_c, pend_c, rdy_c} !== 12'b0)
      begin bad++; $display("FAIL arst_immediate got=%b want=0", {pwm_e, tick_e, pend_e, rdy_e, pwm_c, tick_c, pend_c, rdy_c}); end
    @(negedge clk); rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      highs += int'(pwm_e[0]) + int'(pwm_e[1]) + int'(pwm_c[0]) + int'(pwm_c[1]);
      total++;
      if ({pwm_e, tick_e, pend_e, pwm_c, tick_c, pend_c} !== {m_pwm[0], m_tick[0], m_pend[0], m_pwm[1], m_tick[1], m_pend[1]})
        begin bad++; $display("FAIL arst_model t=%0t got=%b want=%b", $time, {pwm_e, tick_e, pend_e, pwm_c, tick_c, pend_c}, {m_pwm[0], m_tick[0], m_pend[0], m_pwm[1], m_tick[1], m_pend[1]}); end
    end
    total++;
    if (highs != 0) begin bad++; $display("FAIL arst_stays_low got=%0d want=0", highs); end
  endtask

  initial begin
    test_reset();
    test_edge_idle();
    test_edge_write();
    test_prescale();
    test_center();
    test_disabled_write();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
